// File: rtl/dram_halfword_bridge_if.sv
// Bus bundle between the MCU DRAM port, the halfword bridge and the 16-bit memory controller.
// The bridge uses the slave view; the MCU/controller side uses the master view.
interface dram_halfword_bridge_if #(parameter int ADDR_BITS = 24);
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [3:0]           mem_byte_enable;
  logic [31:0]          mem_write_data;
  logic                 mem_ack;
  logic [31:0]          mem_read_data;
  logic                 busy;
  logic                 ctl_req;
  logic                 ctl_we;
  logic [ADDR_BITS:0]   ctl_addr;
  logic [1:0]           ctl_be;
  logic [15:0]          ctl_wdata;
  logic                 ctl_ready;
  logic [15:0]          ctl_rdata;
  logic                 ctl_rvalid;

  modport slave (
    input  mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data,
    input  ctl_ready, ctl_rdata, ctl_rvalid,
    output mem_ack, mem_read_data, busy,
    output ctl_req, ctl_we, ctl_addr, ctl_be, ctl_wdata
  );

  modport master (
    output mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data,
    output ctl_ready, ctl_rdata, ctl_rvalid,
    input  mem_ack, mem_read_data, busy,
    input  ctl_req, ctl_we, ctl_addr, ctl_be, ctl_wdata
  );
endinterface

// File: rtl/dram_halfword_bridge.sv
// Splits 32-bit MCU word accesses into up to two 16-bit controller transfers
// and reassembles read data little-endian.
module dram_halfword_bridge #(
  parameter int ADDR_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_reset,
  dram_halfword_bridge_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic                 r_we;
  logic [15:0]          r_rlo;
  logic [31:0]          r_rdata;

  logic                 w_capture;
  logic                 w_req;
  logic                 w_we;
  logic [ADDR_BITS:0]   w_addr;
  logic [1:0]           w_be;
  logic [15:0]          w_wdata;
  logic                 w_ack;

  assign w_capture = (r_state == IDLE) && (bus.mem_write_en || bus.mem_read_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rlo   <= '0;
      r_rdata <= '0;
    end else if (sync_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rlo   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_addr  <= bus.mem_addr;
        r_be    <= bus.mem_byte_enable;
        r_wdata <= bus.mem_write_data;
        r_we    <= bus.mem_write_en;
      end
      // Low half is staged so the visible read word only changes at completion
      if (r_state == LO_WAIT && bus.ctl_rvalid)
        r_rlo <= bus.ctl_rdata;
      if (r_state == HI_WAIT && bus.ctl_rvalid)
        r_rdata <= {bus.ctl_rdata, r_rlo};
    end
  end

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_be    = 2'b00;
    w_wdata = 16'h0000;
    w_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        // Write wins when both enables arrive together
        if (bus.mem_write_en) begin
          if (bus.mem_byte_enable[1:0] != 2'b00)      w_next = LO_REQ;
          else if (bus.mem_byte_enable[3:2] != 2'b00) w_next = HI_REQ;
          else                                        w_next = DONE;
        end else if (bus.mem_read_en) begin
          w_next = LO_REQ;
        end
      end
      LO_REQ: begin
        w_req   = 1'b1;
        w_we    = r_we;
        w_addr  = {r_addr, 1'b0};
        w_be    = r_we ? r_be[1:0] : 2'b11;
        w_wdata = r_wdata[15:0];
        if (bus.ctl_ready) begin
          if (!r_we)                  w_next = LO_WAIT;
          else if (r_be[3:2] != 2'b00) w_next = HI_REQ;
          else                        w_next = DONE;
        end
      end
      LO_WAIT: begin
        if (bus.ctl_rvalid) w_next = HI_REQ;
      end
      HI_REQ: begin
        w_req   = 1'b1;
        w_we    = r_we;
        w_addr  = {r_addr, 1'b1};
        w_be    = r_we ? r_be[3:2] : 2'b11;
        w_wdata = r_wdata[31:16];
        if (bus.ctl_ready) w_next = r_we ? DONE : HI_WAIT;
      end
      HI_WAIT: begin
        if (bus.ctl_rvalid) w_next = DONE;
      end
      DONE: begin
        w_ack  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.ctl_req       = w_req;
  assign bus.ctl_we        = w_we;
  assign bus.ctl_addr      = w_addr;
  assign bus.ctl_be        = w_be;
  assign bus.ctl_wdata     = w_wdata;
  assign bus.mem_ack       = w_ack;
  assign bus.busy          = (r_state != IDLE);
  assign bus.mem_read_data = r_rdata;

endmodule

// File: tb/tb_dram_halfword_bridge.sv
// Scoreboard bench for dram_halfword_bridge: expected controller transfers and
// ack read words are queued at stimulus time and checked as the DUT produces them.
module tb_dram_halfword_bridge;
  localparam int AB = 24;

  typedef struct packed {
    logic        we;
    logic [AB:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } xfer_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic sync_reset = 1'b0;

  dram_halfword_bridge_if #(.ADDR_BITS(AB)) bus ();

  dram_halfword_bridge #(.ADDR_BITS(AB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          ackSeen = 0;
  int          acksExpected = 0;
  xfer_t       xferQ[$];
  logic [31:0] ackQ[$];
  logic [15:0] rdataQ[$];
  logic [31:0] expRdata = 32'h0;
  logic        autoRvalid = 1'b1;
  logic        manualRvalid = 1'b0;
  logic [15:0] manualRdata = 16'h0;
  logic        respAccept;
  xfer_t       monFront;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Controller model: returns one queued halfword the cycle after each accepted read
  always begin
    @(negedge clk);
    respAccept = bus.ctl_req & bus.ctl_ready & ~bus.ctl_we & autoRvalid;
    @(posedge clk);
    #1;
    if (autoRvalid) begin
      bus.ctl_rvalid = respAccept;
      bus.ctl_rdata  = (respAccept && rdataQ.size() != 0) ? rdataQ.pop_front() : 16'h0;
    end else begin
      bus.ctl_rvalid = manualRvalid;
      bus.ctl_rdata  = manualRdata;
    end
  end

  // Monitor: every requesting cycle must match the head transfer, popped on acceptance
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ctl_req) begin
        checkOutput("xferPending", 32'(xferQ.size() != 0), 32'd1);
        if (xferQ.size() != 0) begin
          monFront = xferQ[0];
          checkOutput("ctlWe", 32'(bus.ctl_we), 32'(monFront.we));
          checkOutput("ctlAddr", 32'(bus.ctl_addr), 32'(monFront.addr));
          checkOutput("ctlBe", 32'(bus.ctl_be), 32'(monFront.be));
          if (monFront.we) checkOutput("ctlWdata", 32'(bus.ctl_wdata), 32'(monFront.wdata));
          checkOutput("busyXfer", 32'(bus.busy), 32'd1);
          if (bus.ctl_ready) void'(xferQ.pop_front());
        end
      end
      if (bus.mem_ack) begin
        ackSeen++;
        checkOutput("ackPending", 32'(ackQ.size() != 0), 32'd1);
        if (ackQ.size() != 0) checkOutput("readData", bus.mem_read_data, ackQ.pop_front());
      end
    end
  end

  task automatic pushXfer(input logic we, input logic [AB:0] addr, input logic [1:0] be, input logic [15:0] wdata);
    xfer_t x;
    x.we = we; x.addr = addr; x.be = be; x.wdata = wdata;
    xferQ.push_back(x);
  endtask

  // Drives a one-cycle request; returns just after the capture edge
  task automatic applyStimulus(input logic we, input logic re, input logic [AB-1:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               input logic [15:0] lo, input logic [15:0] hi, input logic abort);
    if (we) begin
      if (be[1:0] != 2'b00) pushXfer(1'b1, {addr, 1'b0}, be[1:0], data[15:0]);
      if (!abort && be[3:2] != 2'b00) pushXfer(1'b1, {addr, 1'b1}, be[3:2], data[31:16]);
    end else begin
      pushXfer(1'b0, {addr, 1'b0}, 2'b11, 16'h0);
      if (!abort) begin
        pushXfer(1'b0, {addr, 1'b1}, 2'b11, 16'h0);
        rdataQ.push_back(lo);
        rdataQ.push_back(hi);
        expRdata = {hi, lo};
      end
    end
    if (!abort) begin
      ackQ.push_back(expRdata);
      acksExpected++;
    end
    @(posedge clk);
    #1;
    bus.mem_write_en    = we;
    bus.mem_read_en     = re;
    bus.mem_addr        = addr;
    bus.mem_byte_enable = be;
    bus.mem_write_data  = data;
    @(posedge clk);
    #1;
    bus.mem_write_en = 1'b0;
    bus.mem_read_en  = 1'b0;
  endtask

  task automatic waitAck(input int expLat, input string tag);
    int lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.mem_ack) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
    checkOutput(tag, 32'(lat), 32'(expLat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.mem_addr = '0; bus.mem_read_en = 1'b0; bus.mem_write_en = 1'b0;
    bus.mem_byte_enable = 4'h0; bus.mem_write_data = 32'h0;
    bus.ctl_ready = 1'b1; bus.ctl_rdata = 16'h0; bus.ctl_rvalid = 1'b0;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAck", 32'(bus.mem_ack), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstReq", 32'(bus.ctl_req), 32'd0);
    checkOutput("rstAddr", 32'(bus.ctl_addr), 32'd0);
    checkOutput("rstRdata", bus.mem_read_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 24'h000010, 4'hF, 32'hDEADBEEF, 16'h0, 16'h0, 1'b0);
    waitAck(3, "latFullWrite");
    applyStimulus(1'b1, 1'b0, 24'h000010, 4'b1100, 32'h12345678, 16'h0, 16'h0, 1'b0);
    waitAck(2, "latHiWrite");
    applyStimulus(1'b1, 1'b0, 24'h00ABCD, 4'b0001, 32'h12345678, 16'h0, 16'h0, 1'b0);
    waitAck(2, "latLoWrite");
    applyStimulus(1'b1, 1'b0, 24'h000011, 4'b0000, 32'h12345678, 16'h0, 16'h0, 1'b0);
    waitAck(1, "latNoBeWrite");

    applyStimulus(1'b0, 1'b1, 24'h000005, 4'hF, 32'h0, 16'hA5A5, 16'h3C3C, 1'b0);
    waitAck(5, "latRead");
    checkOutput("readWord", bus.mem_read_data, 32'h3C3CA5A5);
    applyStimulus(1'b1, 1'b0, 24'h000006, 4'hF, 32'h0BADF00D, 16'h0, 16'h0, 1'b0);
    waitAck(3, "latWriteAfterRead");
    checkOutput("readHold", bus.mem_read_data, 32'h3C3CA5A5);

    // Stall the low half for seven cycles
    bus.ctl_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h123456, 4'hF, 32'hCAFEF00D, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("busyStall", 32'(bus.busy), 32'd1);
      checkOutput("ackStall", 32'(bus.mem_ack), 32'd0);
      @(posedge clk);
    end
    #1 bus.ctl_ready = 1'b1;
    waitAck(3, "latAfterStall");

    // Both enables together, then read pulses while busy
    bus.ctl_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 24'h000040, 4'hF, 32'h55AA33CC, 16'h0, 16'h0, 1'b0);
    bus.mem_read_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_read_en = 1'b0;
    bus.ctl_ready = 1'b1;
    waitAck(3, "latBothEn");
    repeat (10) @(posedge clk);
    checkOutput("ackCountBusy", 32'(ackSeen), 32'(acksExpected));

    // Async reset while waiting for the low read halfword
    autoRvalid = 1'b0;
    applyStimulus(1'b0, 1'b1, 24'h000077, 4'hF, 32'h0, 16'h0, 16'h0, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("busyLoWait", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    expRdata = 32'h0;
    #1;
    checkOutput("arstAck", 32'(bus.mem_ack), 32'd0);
    checkOutput("arstBusy", 32'(bus.busy), 32'd0);
    checkOutput("arstReq", 32'(bus.ctl_req), 32'd0);
    checkOutput("arstWe", 32'(bus.ctl_we), 32'd0);
    checkOutput("arstBe", 32'(bus.ctl_be), 32'd0);
    checkOutput("arstRdata", bus.mem_read_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    manualRvalid = 1'b1;
    manualRdata = 16'hBAD0;
    repeat (2) @(posedge clk);
    manualRvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("strayBusy", 32'(bus.busy), 32'd0);
    checkOutput("strayRdata", bus.mem_read_data, 32'd0);
    autoRvalid = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h000009, 4'hF, 32'h0, 16'h1111, 16'h2222, 1'b0);
    waitAck(5, "latReadAfterReset");

    // Synchronous reset abandons a stalled write
    bus.ctl_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h000030, 4'hF, 32'hFEEDFACE, 16'h0, 16'h0, 1'b1);
    sync_reset = 1'b1;
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    xferQ.delete();
    expRdata = 32'h0;
    checkOutput("srstBusy", 32'(bus.busy), 32'd0);
    checkOutput("srstReq", 32'(bus.ctl_req), 32'd0);
    checkOutput("srstRdata", bus.mem_read_data, 32'd0);
    bus.ctl_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 24'h000003, 4'b0011, 32'h0000ABCD, 16'h0, 16'h0, 1'b0);
    waitAck(2, "latAfterSyncReset");

    repeat (5) @(posedge clk);
    checkOutput("ackCountFinal", 32'(ackSeen), 32'(acksExpected));
    checkOutput("xferLeft", 32'(xferQ.size()), 32'd0);
    checkOutput("ackLeft", 32'(ackQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
